// File: rtl/chunked_addsub_seq_if.sv
// Operand/result handshake bundle for the chunked adder/subtractor.
// The producer/consumer side uses master, the arithmetic block uses slave.
interface chunked_addsub_seq_if #(
    parameter int WIDTH = 512
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_addsub_seq.sv
// Multi-cycle wide add/subtract: one CHUNK-bit adder walks the operands
// LSB slice first, carrying between slices in a register.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for operands, in_ready high
// RUN    | adding one slice per clock, idx selects the slice
// DONE   | result held on sum/cout/ovf with out_valid until out_ready
module chunked_addsub_seq #(
    parameter int WIDTH = 512,
    parameter int CHUNK = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunked_addsub_seq_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_params
        $error("chunked_addsub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_next;

    // Operands are stored sliced so the active slice is a plain index.
    logic [NCHUNK-1:0][CHUNK-1:0]   r_a;
    logic [NCHUNK-1:0][CHUNK-1:0]   r_b;
    logic [NCHUNK-1:0][CHUNK-1:0]   r_acc;
    logic [NCHUNK-1:0][CHUNK-1:0]   w_result;
    logic                           r_carry;
    logic [IDXW-1:0]                r_idx;
    logic [WIDTH-1:0]               r_sum;
    logic                           r_cout;
    logic                           r_ovf;
    logic                           r_out_valid;

    logic                           w_accept;
    logic                           w_last;
    logic                           w_release;
    logic                           w_c;
    logic [CHUNK-1:0]               w_s;
    logic                           w_ovf;

    // One slice of the add; b was already inverted at acceptance for subtraction.
    always_comb begin
        {w_c, w_s} = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]} + {{CHUNK{1'b0}}, r_carry};
    end

    // Full result as it will look once the current slice is written.
    always_comb begin
        w_result        = r_acc;
        w_result[r_idx] = w_s;
    end

    assign w_ovf = (r_a[NCHUNK-1][CHUNK-1] == r_b[NCHUNK-1][CHUNK-1]) &&
                   (w_result[NCHUNK-1][CHUNK-1] != r_a[NCHUNK-1][CHUNK-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == IDXW'(NCHUNK - 1)) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, slice walk and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.sub ? ~bus.b : bus.b;
                r_carry <= bus.sub ? ~bus.cin : bus.cin;
                r_idx   <= '0;
            end
            if (r_state == S_RUN) begin
                r_acc[r_idx] <= w_s;
                r_carry      <= w_c;
                if (w_last) begin
                    r_sum       <= w_result;
                    r_cout      <= w_c;
                    r_ovf       <= w_ovf;
                    r_out_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
                r_idx       <= '0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Bench for chunked_addsub_seq: three instances (CHUNK = 64, 512, 1) at
// WIDTH = 512 driven by directed steps; expected results go through a queue.
module tb_chunked_addsub_seq;
    localparam int W = 512;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;

    logic         tb_in_valid  [3];
    logic [W-1:0] tb_a         [3];
    logic [W-1:0] tb_b         [3];
    logic         tb_cin       [3];
    logic         tb_sub       [3];
    logic         tb_out_ready [3];
    logic         tb_in_ready  [3];
    logic         tb_out_valid [3];
    logic [W-1:0] tb_sum       [3];
    logic         tb_cout      [3];
    logic         tb_ovf       [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   lat_of[3] = '{8, 1, 512};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 64 : ((g == 1) ? 512 : 1);
        chunked_addsub_seq_if #(.WIDTH(W)) bus ();
        assign bus.in_valid    = tb_in_valid[g];
        assign bus.a           = tb_a[g];
        assign bus.b           = tb_b[g];
        assign bus.cin         = tb_cin[g];
        assign bus.sub         = tb_sub[g];
        assign bus.out_ready   = tb_out_ready[g];
        assign tb_in_ready[g]  = bus.in_ready;
        assign tb_out_valid[g] = bus.out_valid;
        assign tb_sum[g]       = bus.sum;
        assign tb_cout[g]      = bus.cout;
        assign tb_ovf[g]       = bus.ovf;
        chunked_addsub_seq #(.WIDTH(W), .CHUNK(CH)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input int lat);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.lat  = lat;
        return e;
    endfunction

    // Reference: full-width arithmetic in one step.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input int lat);
        logic [W-1:0] bp;
        logic         c0;
        logic [W:0]   r;
        bp = sub ? ~b : b;
        c0 = sub ? ~cin : cin;
        r  = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
        return mk(r[W-1:0], r[W], (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]), lat);
    endfunction

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Present operands, wait for acceptance, then scramble the inputs.
    task automatic start_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input exp_t e);
        int w;
        w = 0;
        while (tb_in_ready[i] !== 1'b1 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_op", {{(W-1){1'b0}}, tb_in_ready[i]}, 1);
        tb_a[i]        = a;
        tb_b[i]        = b;
        tb_cin[i]      = cin;
        tb_sub[i]      = sub;
        tb_in_valid[i] = 1'b1;
        @(posedge clk); #1;
        tb_in_valid[i] = 1'b0;
        tb_a[i]        = ~a;
        tb_b[i]        = ~b;
        tb_cin[i]      = ~cin;
        tb_sub[i]      = ~sub;
        sb.push_back(e);
        chk("in_ready_busy", {{(W-1){1'b0}}, tb_in_ready[i]}, 0);
    endtask

    // Wait for the result, check it against the queue head, optionally stall, then release.
    task automatic finish_op(input int i, input int hold);
        exp_t         e;
        int           n;
        logic [W-1:0] s0;
        logic         c0;
        logic         o0;
        e = sb.pop_front();
        n = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (tb_out_valid[i] === 1'b1) break;
        end
        chk("latency", n, e.lat);
        chk("sum", tb_sum[i], e.sum);
        chk("cout", {{(W-1){1'b0}}, tb_cout[i]}, {{(W-1){1'b0}}, e.cout});
        chk("ovf", {{(W-1){1'b0}}, tb_ovf[i]}, {{(W-1){1'b0}}, e.ovf});
        s0 = tb_sum[i];
        c0 = tb_cout[i];
        o0 = tb_ovf[i];
        for (int h = 0; h < hold; h++) begin
            tb_in_valid[i] = 1'b1;
            tb_a[i]        = rnd_wide();
            tb_b[i]        = rnd_wide();
            tb_sub[i]      = h[0];
            @(posedge clk); #1;
            chk("hold_sum", tb_sum[i], s0);
            chk("hold_cout_ovf", {{(W-2){1'b0}}, tb_cout[i], tb_ovf[i]}, {{(W-2){1'b0}}, c0, o0});
            chk("hold_in_ready", {{(W-1){1'b0}}, tb_in_ready[i]}, 0);
            chk("hold_out_valid", {{(W-1){1'b0}}, tb_out_valid[i]}, 1);
        end
        tb_in_valid[i]  = 1'b0;
        tb_out_ready[i] = 1'b1;
        @(posedge clk); #1;
        tb_out_ready[i] = 1'b0;
        chk("release_out_valid", {{(W-1){1'b0}}, tb_out_valid[i]}, 0);
        chk("release_in_ready", {{(W-1){1'b0}}, tb_in_ready[i]}, 1);
    endtask

    task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input exp_t e);
        start_op(i, a, b, cin, sub, e);
        finish_op(i, 0);
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] one;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           lat;
        ones = '1;
        one  = {{(W-1){1'b0}}, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tb_in_valid[i]  = 1'b0;
            tb_a[i]         = '0;
            tb_b[i]         = '0;
            tb_cin[i]       = 1'b0;
            tb_sub[i]       = 1'b0;
            tb_out_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", {{(W-1){1'b0}}, tb_out_valid[i]}, 0);
            chk("rst_sum", tb_sum[i], '0);
            chk("rst_cout_ovf", {{(W-2){1'b0}}, tb_cout[i], tb_ovf[i]}, 0);
            chk("rst_in_ready", {{(W-1){1'b0}}, tb_in_ready[i]}, 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases on every slice width.
        for (int i = 0; i < 3; i++) begin
            lat = lat_of[i];
            run_op(i, ones, one, 1'b0, 1'b0, mk('0, 1'b1, 1'b0, lat));
            run_op(i, {{(W-64){1'b0}}, {64{1'b1}}}, one, 1'b0, 1'b0,
                   mk(one << 64, 1'b0, 1'b0, lat));
            run_op(i, W'(5), W'(7), 1'b0, 1'b1, mk({{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0, lat));
            run_op(i, W'(7), W'(5), 1'b1, 1'b1, mk(one, 1'b1, 1'b0, lat));
            run_op(i, {1'b0, {(W-1){1'b1}}}, one, 1'b0, 1'b0,
                   mk({1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, lat));
            run_op(i, {1'b1, {(W-1){1'b0}}}, one, 1'b0, 1'b1,
                   mk({1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1, lat));
        end

        // Stalled consumer with in_valid pulsing; nothing may be captured.
        start_op(0, W'(100), W'(23), 1'b1, 1'b0, mk(W'(124), 1'b0, 1'b0, 8));
        finish_op(0, 5);
        repeat (12) @(posedge clk);
        #1;
        chk("no_capture_out_valid", {{(W-1){1'b0}}, tb_out_valid[0]}, 0);
        chk("no_capture_in_ready", {{(W-1){1'b0}}, tb_in_ready[0]}, 1);

        // Reset while idx==3, then a fresh operation.
        start_op(0, ones, ones, 1'b1, 1'b0, mk('0, 1'b0, 1'b0, 8));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", {{(W-1){1'b0}}, tb_out_valid[0]}, 0);
        chk("midrst_sum", tb_sum[0], '0);
        chk("midrst_in_ready", {{(W-1){1'b0}}, tb_in_ready[0]}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, W'(3), W'(4), 1'b0, 1'b0, mk(W'(7), 1'b0, 1'b0, 8));

        // Random operands against the full-width reference.
        for (int k = 0; k < 6; k++) begin
            int i;
            i  = (k < 3) ? 0 : ((k < 5) ? 1 : 2);
            ra = rnd_wide();
            rb = rnd_wide();
            rc = $urandom_range(0, 1) == 1;
            rs = $urandom_range(0, 1) == 1;
            run_op(i, ra, rb, rc, rs, model(ra, rb, rc, rs, lat_of[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
